// File: rtl/calc_op_sequencer_pkg.sv
// Shared widths, opcode values and FSM state encoding for the calculator
// operation sequencer and its helpers.
package calc_op_sequencer_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_ABS = 3'b010,
    OP_MUL = 3'b011
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_NEG,
    S_ACC,
    S_DONE
  } state_e;

endpackage

// File: rtl/calc_op_sequencer_rise_detect.sv
// Single-cycle rising-edge detector: one history flop and an AND-NOT.
module calc_op_sequencer_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/calc_op_sequencer.sv
// Drives the shared signed ALU for one requester: single-pass ADD/SUB/ABS,
// or MUL as a sign-folding negate followed by |B| repeated adds.
module calc_op_sequencer
  import calc_op_sequencer_pkg::*;
#(
  parameter int W   = DATA_W,
  parameter int OPW = OP_W
) (
  input  logic           CLOCK_50,
  input  logic           RESET_N,
  input  logic           start,
  input  logic [OPW-1:0] op_in,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_r,
  input  logic           alu_ovf,
  output logic [W-1:0]   result,
  output logic           ovf,
  output logic           busy,
  output logic           done
);

  state_e         state;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [OPW-1:0] op_r;
  logic [W-1:0]   acc;
  logic [W-1:0]   cnt;
  logic           s_ovf;
  logic           start_rise;

  calc_op_sequencer_rise_detect u_start_rise (
    .clk  (CLOCK_50),
    .rst_n(RESET_N),
    .d    (start),
    .rise (start_rise)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the operand/accumulator registers are reset too, so an aborted
      // operation leaves nothing behind that could leak into the ALU bus.
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      acc    <= '0;
      cnt    <= '0;
      s_ovf  <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here; each state reads the values the
      // registers held at the start of the cycle, never ones updated above.
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_rise) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          a_r   <= a_in;
          b_r   <= b_in;
          op_r  <= op_in;
          acc   <= '0;
          s_ovf <= 1'b0;
          cnt   <= b_in;
          case (op_in)
            OP_ADD, OP_SUB, OP_ABS: state <= S_EXEC;
            OP_MUL:                 state <= b_in[W-1] ? S_NEG : S_ACC;
            default: begin
              result <= '0;
              ovf    <= 1'b1;
              done   <= 1'b1;
              state  <= S_DONE;
            end
          endcase
        end
        S_EXEC: begin
          result <= alu_r;
          ovf    <= alu_ovf;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_NEG: begin
          // A takes the sign of the product so the adds only ever count up;
          // negating -8 is the one case that already overflows here.
          a_r   <= alu_r;
          s_ovf <= s_ovf | alu_ovf;
          cnt   <= ~b_r + W'(1);
          state <= S_ACC;
        end
        S_ACC: begin
          if (cnt == '0) begin
            result <= acc;
            ovf    <= s_ovf;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            acc   <= alu_r;
            s_ovf <= s_ovf | alu_ovf;
            cnt   <= cnt - W'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The ALU is combinational and sampled at the end of the same cycle, so its
  // inputs follow the current state rather than being registered a cycle ahead.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_ADD;
    case (state)
      S_EXEC: begin
        alu_a  = a_r;
        alu_b  = b_r;
        alu_op = op_r;
      end
      S_NEG: begin
        alu_b  = a_r;
        alu_op = OP_SUB;
      end
      S_ACC: begin
        if (cnt != '0) begin
          alu_a = acc;
          alu_b = a_r;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Randomised scoreboard bench for calc_op_sequencer with a behavioural ALU
// and an arithmetic reference model of each operation's result and latency.
`timescale 1ns/1ps
module tb_calc_op_sequencer;

  typedef struct {
    logic [3:0] res;
    logic       ovf;
    int         due;
  } exp_t;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic       start    = 1'b0;
  logic [2:0] op_in    = 3'd0;
  logic [3:0] a_in     = 4'd0;
  logic [3:0] b_in     = 4'd0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_r;
  logic       alu_ovf;
  logic [3:0] result;
  logic       ovf;
  logic       busy;
  logic       done;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   alu_full;
  exp_t q[$];

  calc_op_sequencer dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .start   (start),
    .op_in   (op_in),
    .a_in    (a_in),
    .b_in    (b_in),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_r   (alu_r),
    .alu_ovf (alu_ovf),
    .result  (result),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Behavioural 4-bit signed ALU.
  function automatic int alu_calc(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int x;
    int y;
    x = int'($signed(a));
    y = int'($signed(b));
    case (op)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return (x < 0) ? -x : x;
      default: return 0;
    endcase
  endfunction

  assign alu_full = alu_calc(alu_op, alu_a, alu_b);
  assign alu_r    = alu_full[3:0];
  assign alu_ovf  = (alu_full < -8) || (alu_full > 7);

  // Reference: exact signed arithmetic, truncated result, range-check overflow.
  function automatic exp_t model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int   sa;
    int   sb;
    int   p;
    int   lat;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    p   = 0;
    lat = 3;
    case (op)
      3'd0: p = sa + sb;
      3'd1: p = sa - sb;
      3'd2: p = (sa < 0) ? -sa : sa;
      3'd3: begin
        p   = sa * sb;
        lat = (sb < 0) ? 4 - sb : 3 + sb;
      end
      default: begin
        p   = 99;
        lat = 2;
      end
    endcase
    if (op[2]) begin
      e.res = 4'd0;
      e.ovf = 1'b1;
    end else begin
      e.res = p[3:0];
      e.ovf = (p < -8) || (p > 7);
    end
    e.due = lat;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLOCK_50) begin
    if (RESET_N && done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("done_cycle", cyc, e.due);
        check("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  // Issues one operation at a negedge (cycle 0), drops start in cycle 1 and
  // scrambles the inputs in cycle 2 to prove they were latched.
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e     = model(op, a, b);
    e.due = e.due + cyc;
    op_in = op;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    q.push_back(e);
    @(negedge CLOCK_50);
    start = 1'b0;
    check("busy_c1", 32'(busy), 32'd1);
    @(negedge CLOCK_50);
    op_in = 3'($urandom_range(0, 7));
    a_in  = 4'($urandom_range(0, 15));
    b_in  = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while ((busy || q.size() != 0) && n < 100);
    check("drain", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic run(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    issue(op, a, b);
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge CLOCK_50);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_alu_bus", {21'd0, alu_op, alu_a, alu_b}, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);

    check("busy_c0", 32'(busy), 32'd0);
    issue(3'd0, 4'd0, 4'd1);
    check("busy_c2", 32'(busy), 32'd1);
    @(negedge CLOCK_50);
    check("busy_c3", 32'(busy), 32'd1);
    @(negedge CLOCK_50);
    check("busy_c4", 32'(busy), 32'd0);
    wait_idle();

    run(3'd0, 4'd7, 4'd1);
    run(3'd1, 4'h8, 4'd1);
    run(3'd1, 4'hE, 4'd3);
    run(3'd2, 4'h8, 4'd0);
    run(3'd3, 4'd3, 4'hE);
    run(3'd3, 4'd2, 4'hC);
    run(3'd3, 4'hF, 4'h8);
    run(3'd3, 4'h8, 4'hF);
    run(3'd3, 4'd5, 4'd0);
    run(3'd5, 4'd3, 4'd3);

    // Start held high across two operations' worth of cycles: one completion.
    begin
      exp_t e;
      e     = model(3'd0, 4'd2, 4'd3);
      e.due = e.due + cyc;
      op_in = 3'd0;
      a_in  = 4'd2;
      b_in  = 4'd3;
      start = 1'b1;
      q.push_back(e);
      repeat (10) @(negedge CLOCK_50);
      start = 1'b0;
      wait_idle();
    end

    // A second start edge during a MUL is ignored.
    issue(3'd3, 4'd3, 4'd5);
    repeat (3) @(negedge CLOCK_50);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge CLOCK_50);

    // Reset in the middle of MUL 7*7 aborts without a completion.
    issue(3'd3, 4'd7, 4'd7);
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b0;
    q.delete();
    #1;
    check("abort_result", 32'(result), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_alu_bus", {21'd0, alu_op, alu_a, alu_b}, 32'd0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (12) @(negedge CLOCK_50);
    run(3'd0, 4'd1, 4'd1);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      run(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
